// File: rtl/mem_responder.sv
// Byte-wide RAM responder with a memory-mapped TX/RX byte FIFO pair in the
// top quarter of the address space (data port at offset 0x0, status at 0x4).
module mem_responder #(
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        io_full
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Address decode
    logic [ADDR_W-1:0] addr;
    logic              unused_addr_hi;
    logic              is_io;
    logic              off_data;
    logic              off_stat;

    assign addr           = mem_a[ADDR_W-1:0];
    assign unused_addr_hi = ^mem_a[31:ADDR_W];
    assign is_io          = (addr[ADDR_W-1:ADDR_W-2] == 2'b11);
    assign off_data       = is_io && (mem_a[3:0] == 4'h0);
    assign off_stat       = is_io && (mem_a[3:0] == 4'h4);

    // RAM storage; contents survive reset
    logic [7:0] ram [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (mem_wr && !is_io) begin
            ram[addr] <= mem_dout;
        end
    end

    // FIFO state
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_din_q, mem_din_d;

    logic tx_full, tx_empty, tx_push_req, tx_push, tx_pop;
    logic rx_full, rx_empty, rx_push, rx_pop;

    assign tx_full     = (tx_cnt_q == DEPTH_C);
    assign tx_empty    = (tx_cnt_q == '0);
    assign rx_full     = (rx_cnt_q == DEPTH_C);
    assign rx_empty    = (rx_cnt_q == '0);

    // A pop in the same cycle frees the slot, so a push into a full TX FIFO is kept
    assign tx_pop      = !tx_empty && tx_ready;
    assign tx_push_req = mem_wr && off_data;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign rx_push     = rx_valid && !rx_full;
    assign rx_pop      = !mem_wr && off_data && !rx_empty;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        ovf_d       = ovf_q;
        mem_din_d   = mem_din_q;

        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PW'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PW'(1);
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        if (tx_push_req && !tx_push) begin
            ovf_d = 1'b1;
        end else if (mem_wr && off_stat) begin
            ovf_d = 1'b0;
        end

        // Read data is captured from pre-edge state; writes leave mem_din alone
        if (!mem_wr) begin
            if (!is_io) begin
                mem_din_d = ram[addr];
            end else if (off_data) begin
                mem_din_d = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
            end else if (off_stat) begin
                mem_din_d = {5'b0, ovf_q, !rx_empty, tx_full};
            end else begin
                mem_din_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= mem_dout;
        if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            mem_din_q   <= 8'h00;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            ovf_q       <= ovf_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign mem_din  = mem_din_q;
    assign tx_data  = tx_mem[tx_rd_ptr_q];
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign io_full  = tx_full;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_mem_responder;

    localparam int ADDR_W   = 18;
    localparam int DEPTH    = 8;
    localparam int IO_START = 3 << (ADDR_W - 2);
    localparam logic [31:0] IO_BASE = 32'(IO_START);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_a = IO_BASE + 32'h8;
    logic        mem_wr = 1'b1;
    logic [7:0]  mem_dout = 8'h00;
    logic [7:0]  mem_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        io_full;

    mem_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .io_full  (io_full)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model state
    logic [7:0] ram_m [int];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    bit         ovf_m = 1'b0;
    logic [7:0] din_m = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        ovf_m = 1'b0;
        din_m = 8'h00;
    endtask

    // Apply the current inputs to the model as one clock edge would
    task automatic model_step();
        int         key;
        int         off;
        bit         io;
        bit         tx_pop;
        bit         rx_push;
        bit         push_tx;
        logic [7:0] status;
        key     = int'(mem_a[ADDR_W-1:0]);
        off     = int'(mem_a[3:0]);
        io      = (key >= IO_START);
        tx_pop  = tx_ready && (tx_q.size() > 0);
        rx_push = rx_valid && (rx_q.size() < DEPTH);
        status  = 8'(4 * ovf_m + 2 * (rx_q.size() > 0) + (tx_q.size() == DEPTH));
        push_tx = 1'b0;
        if (mem_wr) begin
            if (!io) ram_m[key] = mem_dout;
            else if (off == 0) begin
                push_tx = (tx_q.size() < DEPTH) || tx_pop;
                if (!push_tx) ovf_m = 1'b1;
            end else if (off == 4) ovf_m = 1'b0;
        end else begin
            if (!io) din_m = ram_m[key];
            else if (off == 0) din_m = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            else if (off == 4) din_m = status;
            else din_m = 8'h00;
        end
        if (tx_pop) void'(tx_q.pop_front());
        if (push_tx) tx_q.push_back(mem_dout);
        if (rx_push) rx_q.push_back(rx_data);
    endtask

    task automatic compare_all();
        check("mem_din", mem_din, din_m);
        check("tx_valid", tx_valid, tx_q.size() > 0);
        check("io_full", io_full, tx_q.size() == DEPTH);
        check("rx_ready", rx_ready, rx_q.size() < DEPTH);
        if (tx_q.size() > 0) check("tx_data", tx_data, tx_q[0]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_wr = 1'b1; mem_dout = d;
        cycle();
    endtask

    task automatic rd(input logic [31:0] a);
        mem_a = a; mem_wr = 1'b0; mem_dout = 8'h00;
        cycle();
    endtask

    task automatic idle();
        wr(IO_BASE + 32'h8, 8'h00);
    endtask

    task automatic rd_expect(input string tag, input logic [31:0] a, input logic [7:0] exp);
        rd(a);
        check(tag, mem_din, exp);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_io_full", io_full, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single write then read-back
        wr(32'h10, 8'hA5);
        rd_expect("ram_a5", 32'h10, 8'hA5);

        // Four back-to-back reads
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i), 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) rd_expect("ram_seq", 32'h100 + 32'(i), 8'(8'h11 * (i + 1)));

        // TX fill, overflow, status, drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(IO_BASE, 8'(i));
            if (i == 7) check("tx_full_after8", io_full, 1'b1);
        end
        rd_expect("stat_ovf_full", IO_BASE + 32'h4, 8'h05);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("tx_drain_valid", tx_valid, 1'b1);
            check("tx_drain_data", tx_data, 8'(i));
            idle();
        end
        check("tx_empty_after_drain", tx_valid, 1'b0);
        wr(IO_BASE + 32'h4, 8'hFF);
        rd_expect("stat_ovf_cleared", IO_BASE + 32'h4, 8'h00);

        // RX push and reads
        rx_data = 8'h5A; rx_valid = 1'b1;
        idle();
        rx_valid = 1'b0;
        rd_expect("stat_rx", IO_BASE + 32'h4, 8'h02);
        rd_expect("rx_head", IO_BASE, 8'h5A);
        rd_expect("rx_empty_read", IO_BASE, 8'h00);
        rd_expect("io_other_off", IO_BASE + 32'hC, 8'h00);

        // Push while full and popping
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(IO_BASE, 8'(8'h80 + i));
        check("full_again", io_full, 1'b1);
        tx_ready = 1'b1;
        wr(IO_BASE, 8'h77);
        check("full_kept", io_full, 1'b1);
        tx_ready = 1'b0;
        rd_expect("stat_no_ovf", IO_BASE + 32'h4, 8'h01);
        tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("tx_order", tx_data, 8'(8'h80 + i));
            idle();
        end
        check("tx_last_77", tx_data, 8'h77);
        idle();
        check("tx_done", tx_valid, 1'b0);

        // Asynchronous reset with bytes pending
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(IO_BASE, 8'(8'hC0 + i));
        rd_expect("pre_rst_read", 32'h10, 8'hA5);
        rst = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_mem_din", mem_din, 8'h00);
        check("arst_io_full", io_full, 1'b0);
        check("arst_rx_ready", rx_ready, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rd_expect("stat_after_rst", IO_BASE + 32'h4, 8'h00);
        rd_expect("ram_kept", 32'h10, 8'hA5);

        // Random traffic
        for (int i = 0; i < 16; i++) wr(32'h200 + 32'(i), 8'($urandom));
        repeat (500) begin
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            case ($urandom_range(0, 8))
                0:       wr(32'h200 + 32'($urandom_range(0, 15)), 8'($urandom));
                1:       rd(32'h200 + 32'($urandom_range(0, 15)));
                2, 3:    wr(IO_BASE, 8'($urandom));
                4, 5:    rd(IO_BASE);
                6:       rd(IO_BASE + 32'h4);
                7:       wr(IO_BASE + 32'h4, 8'($urandom));
                default: rd(IO_BASE + 32'(4 * $urandom_range(2, 3)));
            endcase
        end
        rx_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
